quad_gen: RTL and testbench

Quadrature encoder emulator: drives a two-phase A/B Gray-code pair, one edge at a time at a fixed rate, from the current 8-bit position toward a commanded target. It is the transmit-side counterpart of the `quad` decoder. Its `quadA`/`quadB` outputs can be looped into `quad` on the same board, or driven out on pins in place of a mechanical rotary encoder. For every step, a `quad` instance sampling these outputs counts by exactly +1 or −1 in the same direction as `pos`.

---
 rtl/quad_gen.sv | 139 +++++++++++++
 tb/tb_quad_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder emulator.
// Steps an A/B Gray-code pair one edge every PERIOD clocks, from the current
// 8-bit position toward a commanded target, taking the shortest way around
// the 256-position ring. Ties at a distance of 128 resolve downward.
module quad_gen #(
   parameter int PERIOD = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] target,
   output logic       quadA,
   output logic       quadB,
   output logic [7:0] pos,
   output logic       busy,
   output logic       done
);

   localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(PERIOD - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    pos_q, pos_d;
   logic [7:0]    target_q, target_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          quad_a_q, quad_a_d;
   logic          quad_b_q, quad_b_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Remaining distance on the ring. Bit 7 picks the direction, so a
   // distance of exactly 0x80 steps down.
   logic [7:0] diff;
   logic [7:0] step_pos;

   // Direction of the next step and the position it would land on
   always_comb begin
      diff     = target_q - pos_q;
      step_pos = diff[7] ? (pos_q - 8'd1) : (pos_q + 8'd1);
   end

   // Next-state logic for the FSM, the prescaler and the emitted position
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // A load that would not move anything is ignored entirely.
            if (load && (target != pos_q)) begin
               target_d = target;
               cnt_d    = CNT_RELOAD;
               state_d  = RUN;
               busy_d   = 1'b1;
            end
         end

         RUN: begin
            if (load) begin
               // Retarget edge: never steps. A prescaler already at zero
               // waits here so the pending step uses the new target.
               target_d = target;
               if (en && (cnt_q != '0)) begin
                  cnt_d = cnt_q - 1'b1;
               end
               if (target == pos_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else if (en) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  pos_d = step_pos;
                  cnt_d = CNT_RELOAD;
                  if (step_pos == target_q) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Phase outputs follow the next position so they change on the same
   // edge as pos. B = p[1], A = p[1]^p[0] gives 00,10,11,01 counting up.
   always_comb begin
      quad_b_d = pos_d[1];
      quad_a_d = pos_d[1] ^ pos_d[0];
   end

   // State registers with synchronous reset; reset abandons any move
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pos_q    <= 8'd0;
         target_q <= 8'd0;
         cnt_q    <= '0;
         quad_a_q <= 1'b0;
         quad_b_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         quad_a_q <= quad_a_d;
         quad_b_q <= quad_b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign quadA = quad_a_q;
   assign quadB = quad_b_q;
   assign pos   = pos_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: scoreboard bench for quad_gen with PERIOD = 4.
// Stimulus pushes the expected output changes (edge number, pos, A, B, busy,
// done); a monitor pops one entry whenever any output changes.
module tb_quad_gen;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] target;
   logic       quadA, quadB, busy, done;
   logic [7:0] pos;

   quad_gen #(.PERIOD(P)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .target(target),
      .quadA(quadA), .quadB(quadB), .pos(pos), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] pos;
      logic       a, b, busy, done;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  tests = 0;
   int  fails = 0;
   bit  mon_en = 1'b0;
   logic [7:0] p_pos;
   logic p_a, p_b, p_busy, p_done;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected (A,B) for pos[1:0] = 0,1,2,3 along the up sequence
   function automatic ev_t mk(int c, logic [7:0] p, logic bz, logic dn);
      logic [1:0] tab [4];
      ev_t e;
      tab[0] = 2'b00; tab[1] = 2'b10; tab[2] = 2'b11; tab[3] = 2'b01;
      e.cyc = c; e.pos = p; e.a = tab[p[1:0]][1]; e.b = tab[p[1:0]][0];
      e.busy = bz; e.done = dn;
      return e;
   endfunction

   task automatic push(int c, logic [7:0] p, logic bz, logic dn);
      q.push_back(mk(c, p, bz, dn));
   endtask

   // Monitor: every observed output change must match the queue head
   always @(negedge clk) begin
      if (mon_en) begin
         if (pos !== p_pos || quadA !== p_a || quadB !== p_b ||
             busy !== p_busy || done !== p_done) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change: edge %0d pos=%0d A=%b B=%b busy=%b done=%b, required no change",
                        cyc, pos, quadA, quadB, busy, done);
            end else begin
               ev_t e;
               e = q.pop_front();
               if (e.cyc != cyc || e.pos !== pos || e.a !== quadA || e.b !== quadB ||
                   e.busy !== busy || e.done !== done) begin
                  fails++;
                  $display("FAIL event: got edge %0d pos=%0d A=%b B=%b busy=%b done=%b, required edge %0d pos=%0d A=%b B=%b busy=%b done=%b",
                           cyc, pos, quadA, quadB, busy, done,
                           e.cyc, e.pos, e.a, e.b, e.busy, e.done);
               end
            end
         end
         p_pos = pos; p_a = quadA; p_b = quadB; p_busy = busy; p_done = done;
      end
   end

   // Must be called at a negedge; load is sampled on edge L = cyc+1
   task automatic do_load(input logic [7:0] t, output int L);
      load = 1'b1; target = t; L = cyc + 1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic drain(string name, int max);
      int n = 0;
      while (q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL %s_timeout: %0d expected events outstanding, required 0", name, q.size());
         q.delete();
      end
   endtask

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   initial begin
      int L, M, R;
      rst = 1'b1; en = 1'b1; load = 1'b0; target = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_pos",  32'(pos),   32'd0);
      check("reset_a",    32'(quadA), 32'd0);
      check("reset_b",    32'(quadB), 32'd0);
      check("reset_busy", 32'(busy),  32'd0);
      check("reset_done", 32'(done),  32'd0);
      p_pos = pos; p_a = quadA; p_b = quadB; p_busy = busy; p_done = done;
      mon_en = 1'b1;

      // Up move 0 -> 3
      do_load(8'd3, L);
      push(L, 0, 1, 0); push(L+4, 1, 1, 0); push(L+8, 2, 1, 0);
      push(L+12, 3, 0, 1); push(L+13, 3, 0, 0);
      drain("up_move", 40);

      // Single down step 3 -> 2
      do_load(8'd2, L);
      push(L, 3, 1, 0); push(L+4, 2, 0, 1); push(L+5, 2, 0, 0);
      drain("down_one", 20);

      // Wrap down 2 -> 254 through 0 -> 255
      do_load(8'd254, L);
      push(L, 2, 1, 0); push(L+4, 1, 1, 0); push(L+8, 0, 1, 0);
      push(L+12, 255, 1, 0); push(L+16, 254, 0, 1); push(L+17, 254, 0, 0);
      drain("wrap_down", 40);

      // Wrap up 254 -> 0
      do_load(8'd0, L);
      push(L, 254, 1, 0); push(L+4, 255, 1, 0); push(L+8, 0, 0, 1); push(L+9, 0, 0, 0);
      drain("wrap_up", 30);

      // Distance exactly 0x80 goes down: 128 steps
      do_load(8'h80, L);
      push(L, 0, 1, 0);
      for (int k = 1; k <= 128; k++)
         push(L + 4*k, 8'(256 - k), (k == 128) ? 1'b0 : 1'b1, (k == 128) ? 1'b1 : 1'b0);
      push(L + 513, 8'h80, 0, 0);
      drain("half_turn", 700);

      // Idle load of the current position: nothing happens
      do_load(8'h80, L);
      repeat (8) @(negedge clk);
      check("idle_eq_busy", 32'(busy), 32'd0);
      check("idle_eq_pos",  32'(pos),  32'h80);

      // Reset from idle at 0x80
      rst = 1'b1; R = cyc + 1;
      push(R, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drain("reset_idle", 10);

      // Retarget mid-move: 0 -> 10, reversed at pos 4 toward 2
      do_load(8'd10, L);
      push(L, 0, 1, 0); push(L+4, 1, 1, 0); push(L+8, 2, 1, 0);
      push(L+12, 3, 1, 0); push(L+16, 4, 1, 0);
      wait_cyc(L+17);
      do_load(8'd2, M);
      push(L+20, 3, 1, 0); push(L+24, 2, 0, 1); push(L+25, 2, 0, 0);
      drain("retarget", 60);

      // Reload with target = pos ends the move on the load edge
      do_load(8'd6, L);
      push(L, 2, 1, 0); push(L+4, 3, 1, 0); push(L+8, 4, 1, 0);
      wait_cyc(L+9);
      do_load(8'd4, M);
      push(M, 4, 0, 1); push(M+1, 4, 0, 0);
      drain("reload_eq", 40);

      // Load while prescaler is 0: step deferred one edge, uses new target
      do_load(8'd8, L);
      push(L, 4, 1, 0); push(L+4, 5, 1, 0);
      wait_cyc(L+7);
      do_load(8'd9, M);
      push(L+9, 6, 1, 0); push(L+13, 7, 1, 0); push(L+17, 8, 1, 0);
      push(L+21, 9, 0, 1); push(L+22, 9, 0, 0);
      drain("load_at_zero", 60);

      // en low for 7 edges delays the step by 7
      do_load(8'd11, L);
      push(L, 9, 1, 0);
      wait_cyc(L+1);
      en = 1'b0;
      wait_cyc(L+8);
      en = 1'b1;
      push(L+11, 10, 1, 0); push(L+15, 11, 0, 1); push(L+16, 11, 0, 0);
      drain("freeze", 40);

      // Idle load equal to pos again
      do_load(8'd11, L);
      repeat (8) @(negedge clk);
      check("idle_eq2_busy", 32'(busy), 32'd0);
      check("idle_eq2_pos",  32'(pos),  32'd11);

      // Reset mid-move: abandoned, no done
      do_load(8'd20, L);
      push(L, 11, 1, 0); push(L+4, 12, 1, 0); push(L+8, 13, 1, 0);
      wait_cyc(L+9);
      rst = 1'b1; R = cyc + 1;
      push(R, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drain("reset_mid", 20);
      repeat (20) @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_pos",  32'(pos),  32'd0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
